squeeze_serializer: RTL and testbench
=====================================

SQUEEZE_SERIALIZER -- requirements
Module: squeeze_serializer

Interface
REQ-001 Parameter OUT_WIDTH, default 64, output word width in bits; legal values 32 and 64 only (both divide RATE_SHAKE128 and RATE_SHAKE256).
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset; synchronous, active-high.
REQ-004 Port block_valid_in  input  1  upstream permute stage presents a squeezed rate block.
REQ-005 Port block_ready_out  output  1  serializer accepts a block this cycle.
REQ-006 Port rate_input  input  RATE_SHAKE128  squeezed rate, already endian-switched; word i = rate_input[RATE_SHAKE128-1-i*OUT_WIDTH -: OUT_WIDTH].
REQ-007 Port operation_mode_in  input  2  SHAKE128_MODE_VEC or SHAKE256_MODE_VEC (keccak_pkg encodings).
REQ-008 Port output_size_in  input  32  output bits still owed, counted before this block.
REQ-009 Port last_block_in  input  1  upstream flags this block as the final squeeze block.
REQ-010 Port data_out  output  OUT_WIDTH  serialized output word.
REQ-011 Port data_valid_out  output  1  data_out holds a valid word.
REQ-012 Port data_ready_in  input  1  downstream accepts data_out this cycle.
REQ-013 Port data_last_out  output  1  data_out is the final word of the whole squeeze.
REQ-014 Port done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and STREAM.
REQ-016 IDLE: block_ready_out=1, data_valid_out=0; a block handshake (block_valid_in & block_ready_out) SHALL capture rate_input, mode, output_size_in and last_block_in, then go to STREAM.
REQ-017 Rate bits R SHALL be RATE_SHAKE128 for SHAKE128_MODE_VEC and RATE_SHAKE256 for SHAKE256_MODE_VEC; for SHAKE256, only the upper RATE_SHAKE256 bits of rate_input are used.
REQ-018 Word count N SHALL be ceil(min(output_size_in, R)/OUT_WIDTH), held in a 6-bit down-counter.
REQ-019 If N=0 (output_size_in=0) or the mode is invalid, the block SHALL be consumed with no words emitted and the FSM SHALL stay in IDLE; done SHALL pulse if last_block_in=1.
REQ-020 STREAM: data_valid_out=1, block_ready_out=0; data_out = top OUT_WIDTH bits of the capture shift register.
REQ-021 On each word handshake (data_valid_out & data_ready_in), the shift register SHALL shift left by OUT_WIDTH, the word counter SHALL decrement and the remaining-bit count SHALL decrease by OUT_WIDTH, saturating at 0.
REQ-022 While data_valid_out=1 and data_ready_in=0, data_out, data_last_out and all state SHALL hold unchanged.
REQ-023 Final word of a block: if remaining bits r < OUT_WIDTH, data_out[OUT_WIDTH-1 -: r] SHALL carry data and all lower bits SHALL be 0.
REQ-024 data_last_out SHALL be 1 only on the final word of a block where last_block_in was captured as 1, or where the captured output_size_in <= R.
REQ-025 The handshake of a block's final word SHALL return the FSM to IDLE; done SHALL pulse in the next cycle if data_last_out was 1 on that word.
REQ-026 Latency: the first word SHALL be valid one cycle after block capture; a minimum of one bubble cycle lies between consecutive blocks.
REQ-027 block_valid_in SHALL be ignored in STREAM; upstream holds the block until block_ready_out is 1.

Reset
REQ-028 rst=1 SHALL force IDLE, clear the shift register, counters and captured fields, and drive data_valid_out=0, data_last_out=0, done=0, data_out=0 and block_ready_out=1 in the cycle after rst is sampled.
REQ-029 rst asserted mid-STREAM SHALL abandon the block; no further words are emitted and done does not pulse.

Verification
REQ-030 SHAKE128, OUT_WIDTH=64, output_size_in=2000, last_block_in=0, data_ready_in=1 -> 21 words in 21 consecutive cycles, data_last_out=0 throughout, then IDLE.
REQ-031 SHAKE256, output_size_in=256, last_block_in=1 -> 4 words equal to rate_input[1343:1088] split MSB-first, data_last_out=1 on word 4 only, done pulses once.
REQ-032 SHAKE128, output_size_in=100 -> 2 words; word 2 carries the upper 36 bits valid and the low 28 bits 0, with data_last_out=1.
REQ-033 data_ready_in held 0 for 5 cycles during word 3 -> data_out stable for all 5 cycles, no word lost or duplicated, total word count unchanged.
REQ-034 rst pulsed during word 7 of a SHAKE128 block -> next cycle data_valid_out=0, block_ready_out=1; a new block then streams from its word 0.
REQ-035 output_size_in=0 with last_block_in=1 -> block consumed in one cycle, no data_valid_out, done pulses once.

Source files
------------

// File: rtl/squeeze_serializer.sv
// Squeeze-phase output serializer: accepts one squeezed rate block from the
// permute stage and emits it as OUT_WIDTH-bit words, MSB first, trimmed to
// the number of output bits still owed.

package keccak_pkg;
  localparam int unsigned RATE_SHAKE128     = 1344;
  localparam int unsigned RATE_SHAKE256     = 1088;
  localparam logic [1:0]  SHAKE128_MODE_VEC = 2'b10;
  localparam logic [1:0]  SHAKE256_MODE_VEC = 2'b11;
endpackage

module squeeze_serializer
  import keccak_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     block_valid_in,
  output logic                     block_ready_out,
  input  logic [RATE_SHAKE128-1:0] rate_input,
  input  logic [1:0]               operation_mode_in,
  input  logic [31:0]              output_size_in,
  input  logic                     last_block_in,
  output logic [OUT_WIDTH-1:0]     data_out,
  output logic                     data_valid_out,
  input  logic                     data_ready_in,
  output logic                     data_last_out,
  output logic                     done
);

  localparam int unsigned SHIFT  = $clog2(OUT_WIDTH);
  localparam int unsigned BITS_W = 11;   // holds up to RATE_SHAKE128
  localparam int unsigned CNT_W  = 6;    // holds up to RATE_SHAKE128/32

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                   state_q, state_d;
  logic [RATE_SHAKE128-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BITS_W-1:0]        rem_q, rem_d;
  logic                     last_q, last_d;
  logic                     done_q, done_d;

  // Block-side decode
  logic                     mode_128;
  logic                     mode_256;
  logic                     mode_ok;
  logic [31:0]              rate_bits;
  logic                     size_fits;
  logic [BITS_W-1:0]        eff_bits;
  logic [CNT_W-1:0]         words;
  logic [RATE_SHAKE128-1:0] rate_aligned;

  // Word-side decode
  logic [OUT_WIDTH-1:0]     top_word;
  logic [OUT_WIDTH-1:0]     word_mask;

  // Decode the offered block: rate by mode, bits actually owed, word count.
  always_comb begin
    mode_128  = (operation_mode_in == SHAKE128_MODE_VEC);
    mode_256  = (operation_mode_in == SHAKE256_MODE_VEC);
    mode_ok   = mode_128 | mode_256;
    rate_bits = mode_256 ? 32'(RATE_SHAKE256) : 32'(RATE_SHAKE128);
    size_fits = (output_size_in <= rate_bits);
    eff_bits  = size_fits ? output_size_in[BITS_W-1:0] : rate_bits[BITS_W-1:0];
    words     = CNT_W'((eff_bits + BITS_W'(OUT_WIDTH - 1)) >> SHIFT);
    // SHAKE256 uses only the upper part of the rate; zero the unused tail
    rate_aligned = mode_256
      ? {rate_input[RATE_SHAKE128-1 -: RATE_SHAKE256],
         {(RATE_SHAKE128 - RATE_SHAKE256){1'b0}}}
      : rate_input;
  end

  // Current output word, with bits beyond the owed count forced to zero.
  always_comb begin
    top_word  = shreg_q[RATE_SHAKE128-1 -: OUT_WIDTH];
    word_mask = (rem_q < BITS_W'(OUT_WIDTH)) ? ~({OUT_WIDTH{1'b1}} >> rem_q)
                                             : '1;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d         = state_q;
    shreg_d         = shreg_q;
    cnt_d           = cnt_q;
    rem_d           = rem_q;
    last_d          = last_q;
    done_d          = 1'b0;
    block_ready_out = 1'b0;
    data_valid_out  = 1'b0;
    data_out        = '0;
    data_last_out   = 1'b0;

    unique case (state_q)
      IDLE: begin
        block_ready_out = 1'b1;
        if (block_valid_in) begin
          if (mode_ok && (words != '0)) begin
            shreg_d = rate_aligned;
            cnt_d   = words;
            rem_d   = eff_bits;
            last_d  = last_block_in | size_fits;
            state_d = STREAM;
          end else begin
            // Nothing to emit: block is swallowed, completion still reported
            done_d = last_block_in;
          end
        end
      end

      STREAM: begin
        data_valid_out = 1'b1;
        data_out       = top_word & word_mask;
        data_last_out  = (cnt_q == CNT_W'(1)) & last_q;
        if (data_ready_in) begin
          shreg_d = shreg_q << OUT_WIDTH;
          cnt_d   = cnt_q - CNT_W'(1);
          rem_d   = (rem_q > BITS_W'(OUT_WIDTH)) ? rem_q - BITS_W'(OUT_WIDTH)
                                                 : '0;
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = last_q;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_squeeze_serializer.sv
// Directed bench for squeeze_serializer (OUT_WIDTH=64) with an expected-word
// scoreboard filled from an independent reference model.

module tb_squeeze_serializer;

  localparam logic [1:0] M128 = 2'b10;
  localparam logic [1:0] M256 = 2'b11;

  logic          clk;
  logic          rst;
  logic          block_valid_in;
  logic          block_ready_out;
  logic [1343:0] rate_input;
  logic [1:0]    operation_mode_in;
  logic [31:0]   output_size_in;
  logic          last_block_in;
  logic [63:0]   data_out;
  logic          data_valid_out;
  logic          data_ready_in;
  logic          data_last_out;
  logic          done;

  squeeze_serializer #(.OUT_WIDTH(64)) dut (
    .clk               (clk),
    .rst               (rst),
    .block_valid_in    (block_valid_in),
    .block_ready_out   (block_ready_out),
    .rate_input        (rate_input),
    .operation_mode_in (operation_mode_in),
    .output_size_in    (output_size_in),
    .last_block_in     (last_block_in),
    .data_out          (data_out),
    .data_valid_out    (data_valid_out),
    .data_ready_in     (data_ready_in),
    .data_last_out     (data_last_out),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   exp_words = 0;
  int   exp_done  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1343:0] rand_rate();
    logic [1343:0] r;
    for (int i = 0; i < 42; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: words owed, trimming, last flag and done expectation.
  task automatic model_block(input logic [1343:0] rate, input logic [1:0] mode,
                             input logic [31:0] size, input logic last);
    longint        rbits;
    longint        sz;
    longint        eff;
    longint        n;
    longint        bits;
    logic [1343:0] tmp;
    logic [63:0]   w;
    exp_t          e;
    sz    = longint'(size);
    rbits = (mode == M128) ? 1344 : (mode == M256) ? 1088 : 0;
    eff   = (sz < rbits) ? sz : rbits;
    n     = (eff + 63) / 64;
    for (int i = 0; i < n; i++) begin
      tmp  = rate << (64 * i);
      w    = tmp[1343:1280];
      bits = eff - 64 * i;
      for (int b = 0; b < 64; b++) if (b >= bits) w[63-b] = 1'b0;
      e.data = w;
      e.last = (i == n - 1) && (last || (sz <= rbits));
      exp_q.push_back(e);
    end
    exp_words = int'(n);
    if (n == 0) exp_done = last ? 1 : 0;
    else        exp_done = (last || (sz <= rbits)) ? 1 : 0;
  endtask

  // Offer a block and hold it until accepted; returns at posedge+1 of capture.
  task automatic send_block(input string tag, input logic [1343:0] rate,
                            input logic [1:0] mode, input logic [31:0] size,
                            input logic last);
    bit got = 0;
    model_block(rate, mode, size, last);
    @(posedge clk); #1;
    block_valid_in    = 1'b1;
    rate_input        = rate;
    operation_mode_in = mode;
    output_size_in    = size;
    last_block_in     = last;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (block_ready_out) begin got = 1; break; end
      @(posedge clk); #1;
    end
    if (!got) check({tag, "_accept_timeout"}, 64'd0, 64'd1);
    @(posedge clk); #1;
    block_valid_in = 1'b0;
    rate_input     = '0;
  endtask

  // Consume words, checking each against the scoreboard. stall_at/stall_len
  // hold data_ready_in low before a given word; stop_after>=0 ends early.
  task automatic drain(input string tag, input int stall_at, input int stall_len,
                       input int stop_after, input bit check_span);
    int acc = 0, stalls = 0, dones = 0, tail = 0;
    int first_hs = -1, last_hs = -1;
    bit finished = 0;
    exp_t e;
    for (int cyc = 0; cyc < 300; cyc++) begin
      data_ready_in = !((acc == stall_at) && (stalls < stall_len));
      @(negedge clk);
      if (done) dones++;
      if (data_valid_out) begin
        if (exp_q.size() == 0) begin
          check({tag, "_unexpected_word"}, data_out, 64'd0);
          check({tag, "_unexpected_valid"}, 64'(data_valid_out), 64'd0);
        end else begin
          e = exp_q[0];
          check($sformatf("%s_w%0d_data", tag, acc), data_out, e.data);
          check($sformatf("%s_w%0d_last", tag, acc), 64'(data_last_out), 64'(e.last));
          if (data_ready_in) begin
            void'(exp_q.pop_front());
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            acc++;
          end else begin
            stalls++;
          end
        end
      end
      if ((stop_after >= 0) && (acc == stop_after)) begin finished = 1; break; end
      if (exp_q.size() == 0) tail++;
      if (tail >= 3) begin finished = 1; break; end
      @(posedge clk); #1;
    end
    if (!finished) check({tag, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
    if (stop_after < 0) begin
      check({tag, "_word_count"}, 64'(acc), 64'(exp_words));
      check({tag, "_done_pulses"}, 64'(dones), 64'(exp_done));
      check({tag, "_idle_ready"}, 64'(block_ready_out), 64'd1);
      check({tag, "_idle_valid"}, 64'(data_valid_out), 64'd0);
      if (check_span && exp_words > 0)
        check({tag, "_consecutive"}, 64'(last_hs - first_hs), 64'(exp_words - 1));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst               = 1'b1;
    block_valid_in    = 1'b0;
    rate_input        = '0;
    operation_mode_in = M128;
    output_size_in    = '0;
    last_block_in     = 1'b0;
    data_ready_in     = 1'b0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(block_ready_out), 64'd1);
    check("rst_valid", 64'(data_valid_out), 64'd0);
    check("rst_last",  64'(data_last_out), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_data",  data_out, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 21 back-to-back words, never last
    send_block("s128_2000", rand_rate(), M128, 32'd2000, 1'b0);
    drain("s128_2000", -1, 0, -1, 1);

    // SHAKE256 256 bits, final block
    send_block("s256_256", rand_rate(), M256, 32'd256, 1'b1);
    drain("s256_256", -1, 0, -1, 1);

    // Partial final word: 36 valid bits
    send_block("s128_100", rand_rate(), M128, 32'd100, 1'b0);
    drain("s128_100", -1, 0, -1, 1);

    // Backpressure on word 3 for 5 cycles
    send_block("stall", rand_rate(), M128, 32'd640, 1'b1);
    drain("stall", 2, 5, -1, 0);

    // Boundaries around the rates
    send_block("s128_1344", rand_rate(), M128, 32'd1344, 1'b0);
    drain("s128_1344", -1, 0, -1, 1);
    send_block("s128_1345", rand_rate(), M128, 32'd1345, 1'b0);
    drain("s128_1345", -1, 0, -1, 1);
    send_block("s256_1088", rand_rate(), M256, 32'd1088, 1'b0);
    drain("s256_1088", -1, 0, -1, 1);
    send_block("s256_5000", rand_rate(), M256, 32'd5000, 1'b0);
    drain("s256_5000", -1, 0, -1, 1);
    send_block("s128_1", rand_rate(), M128, 32'd1, 1'b0);
    drain("s128_1", -1, 0, -1, 1);
    send_block("s128_64", rand_rate(), M128, 32'd64, 1'b1);
    drain("s128_64", -1, 0, -1, 1);

    // Reset while word 7 is on the output
    send_block("abort", rand_rate(), M128, 32'd1344, 1'b0);
    drain("abort", -1, 0, 6, 0);
    @(posedge clk); #1;
    data_ready_in = 1'b0;
    rst           = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_valid", 64'(data_valid_out), 64'd0);
    check("abort_ready", 64'(block_ready_out), 64'd1);
    check("abort_data",  data_out, 64'd0);
    check("abort_last",  64'(data_last_out), 64'd0);
    check("abort_done",  64'(done), 64'd0);
    exp_q.delete();
    @(negedge clk);
    check("abort_done_after", 64'(done), 64'd0);
    send_block("after_abort", rand_rate(), M128, 32'd300, 1'b1);
    drain("after_abort", -1, 0, -1, 1);

    // Zero-length final block
    send_block("zero", rand_rate(), M128, 32'd0, 1'b1);
    drain("zero", -1, 0, -1, 0);

    // Unsupported mode is swallowed
    send_block("badmode", rand_rate(), 2'b01, 32'd100, 1'b1);
    drain("badmode", -1, 0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
